// File: rtl/sort_pulse_pkg.sv
// Shared definitions for the droplet sort pulse generator: register map,
// reset defaults and the actuation FSM states.
package sort_pulse_pkg;

  localparam logic [19:0] REG_CTRL    = 20'h00000;
  localparam logic [19:0] REG_DELAY   = 20'h00004;
  localparam logic [19:0] REG_WIDTH   = 20'h00008;
  localparam logic [19:0] REG_FIRED   = 20'h0000C;
  localparam logic [19:0] REG_DROPPED = 20'h00010;
  localparam logic [19:0] REG_PENDING = 20'h00014;

  localparam logic [30:0] DELAY_RST = 31'd1000;
  localparam logic [31:0] WIDTH_RST = 32'd100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_e;

endpackage

// File: rtl/red_pitaya_sort_fifo.sv
// Queue of pending fire times. The head is read combinationally; a push is
// accepted on a full queue when a pop happens in the same cycle.
module red_pitaya_sort_fifo #(
  parameter int QLOG2 = 3,
  parameter int TW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [TW-1:0]    din,
  output logic             full,
  output logic             empty,
  output logic [QLOG2:0]   count,
  output logic [TW-1:0]    head
);

  localparam int DEPTH = 1 << QLOG2;

  logic [TW-1:0]    mem_q [DEPTH];
  logic [QLOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [QLOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [QLOG2:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = count_q[QLOG2];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/red_pitaya_sort_pulse.sv
// Turns FADS sort decisions into delayed, fixed-width actuation pulses for the
// ASG trigger and HV gate, with a queue of droplets still in flight.
module red_pitaya_sort_pulse
  import sort_pulse_pkg::*;
#(
  parameter int QLOG2 = 3,
  parameter int TW    = 32
) (
  input  logic        adc_clk_i,
  input  logic        adc_rst_i,
  input  logic        sort_trig_i,
  output logic        asg_trig_o,
  output logic        sort_gate_o,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_sel,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);

  logic [TW-1:0] now_q, now_d;
  logic          trig_prev_q, trig_prev_d;
  logic          enable_q, enable_d;
  logic [30:0]   delay_q, delay_d;
  logic [TW-1:0] width_q, width_d;
  logic [TW-1:0] fired_q, fired_d;
  logic [TW-1:0] dropped_q, dropped_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  state_e        state_q, state_d;
  logic          asg_q, asg_d;
  logic          gate_q, gate_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [19:0]   addr;
  logic          clr_cnt, push, fire, drop, due;
  logic [TW-1:0] delay_eff, width_eff, push_val, head, age;
  logic          q_full, q_empty;
  logic [QLOG2:0] q_count;
  logic          unused_ok;

  assign unused_ok = ^{sys_sel, sys_addr[31:20]};
  assign addr      = sys_addr[19:0];
  assign clr_cnt   = sys_wen && (addr == REG_CTRL) && sys_wdata[1];

  // Due time is latched one past the current count so the pulse lands D+1
  // cycles after the sampling edge; DELAY stays below 2^31, keeping the
  // signed age comparison valid across a wrap of now.
  assign delay_eff = (delay_q == '0) ? TW'(1) : TW'(delay_q);
  assign width_eff = (width_q == '0) ? TW'(1) : width_q;
  assign push_val  = now_q + TW'(1) + delay_eff;
  assign age       = now_q - head;
  assign due       = !age[TW-1];

  assign push = sort_trig_i && !trig_prev_q && enable_q;
  assign fire = (state_q == ST_IDLE) && enable_q && !q_empty && due;
  assign drop = push && q_full && !fire;

  red_pitaya_sort_fifo #(.QLOG2(QLOG2), .TW(TW)) u_fifo (
    .clk   (adc_clk_i),
    .rst   (adc_rst_i),
    .push  (push),
    .pop   (fire),
    .flush (!enable_q),
    .din   (push_val),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count),
    .head  (head)
  );

  always_comb begin
    now_d       = now_q + TW'(1);
    trig_prev_d = sort_trig_i;
    enable_d    = enable_q;
    delay_d     = delay_q;
    width_d     = width_q;
    ack_d       = sys_wen || sys_ren;
    rdata_d     = '0;
    if (sys_wen) begin
      case (addr)
        REG_CTRL:  enable_d = sys_wdata[0];
        REG_DELAY: delay_d  = sys_wdata[30:0];
        REG_WIDTH: width_d  = TW'(sys_wdata);
        default:   ;
      endcase
    end
    if (sys_ren) begin
      case (addr)
        REG_CTRL:    rdata_d = {31'd0, enable_q};
        REG_DELAY:   rdata_d = {1'b0, delay_q};
        REG_WIDTH:   rdata_d = 32'(width_q);
        REG_FIRED:   rdata_d = 32'(fired_q);
        REG_DROPPED: rdata_d = 32'(dropped_q);
        REG_PENDING: rdata_d = 32'(q_count);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    fired_d   = fired_q;
    dropped_d = dropped_q;
    if (clr_cnt) begin
      fired_d   = '0;
      dropped_d = '0;
    end else begin
      if (fire && !(&fired_q))  fired_d   = fired_q + TW'(1);
      if (drop && !(&dropped_q)) dropped_d = dropped_q + TW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    asg_d   = 1'b0;
    gate_d  = gate_q;
    case (state_q)
      ST_IDLE: begin
        gate_d = 1'b0;
        if (fire) begin
          state_d = ST_PULSE;
          asg_d   = 1'b1;
          gate_d  = 1'b1;
          wcnt_d  = width_eff;
        end
      end
      ST_PULSE: begin
        // Losing enable must kill the HV gate immediately.
        if (!enable_q || wcnt_q == TW'(1)) begin
          state_d = ST_IDLE;
          gate_d  = 1'b0;
        end else begin
          wcnt_d = wcnt_q - TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gate_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      now_q       <= '0;
      trig_prev_q <= 1'b0;
      enable_q    <= 1'b0;
      delay_q     <= DELAY_RST;
      width_q     <= TW'(WIDTH_RST);
      fired_q     <= '0;
      dropped_q   <= '0;
      wcnt_q      <= '0;
      state_q     <= ST_IDLE;
      asg_q       <= 1'b0;
      gate_q      <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      now_q       <= now_d;
      trig_prev_q <= trig_prev_d;
      enable_q    <= enable_d;
      delay_q     <= delay_d;
      width_q     <= width_d;
      fired_q     <= fired_d;
      dropped_q   <= dropped_d;
      wcnt_q      <= wcnt_d;
      state_q     <= state_d;
      asg_q       <= asg_d;
      gate_q      <= gate_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
    end
  end

  assign asg_trig_o  = asg_q;
  assign sort_gate_o = gate_q;
  assign sys_ack     = ack_q;
  assign sys_rdata   = rdata_q;
  assign sys_err     = 1'b0;

endmodule
